// File: rtl/game_sequencer.sv
// Round controller for the rhythm game: difficulty select, countdown, play and
// result phases, with its own beat timebase matched to main_game's scroll rate.
module game_sequencer #(
  parameter logic [22:0] DIFF_EASY   = 23'd6_000_000,
  parameter logic [22:0] DIFF_MED    = 23'd4_000_000,
  parameter logic [22:0] DIFF_HARD   = 23'd2_000_000,
  parameter int          COUNT_BEATS = 3,
  parameter int          SONG_BEATS  = 40,
  parameter logic [7:0]  MISS_LIMIT  = 8'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        sel_btn,
  input  logic [7:0]  num_misses,
  input  logic [7:0]  num_hits,
  output logic [2:0]  mode,
  output logic [22:0] diff,
  output logic [1:0]  level,
  output logic        song_load,
  output logic [5:0]  beat_cnt,
  output logic        game_over,
  output logic        won,
  output logic [7:0]  final_hits
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECT    = 3'd1,
    S_COUNTDOWN = 3'd2,
    S_PLAY      = 3'd3,
    S_WIN       = 3'd4,
    S_LOSE      = 3'd5
  } state_t;

  localparam logic [5:0] COUNT_LAST = 6'(COUNT_BEATS - 1);
  localparam logic [5:0] SONG_LAST  = 6'(SONG_BEATS - 1);

  state_t      state_r;
  state_t      next_state_s;
  logic [2:0]  start_sh_r;
  logic [2:0]  sel_sh_r;
  logic        start_p_r;
  logic        sel_p_r;
  logic [22:0] tick_cnt_r;
  logic [5:0]  beat_cnt_r;
  logic [22:0] diff_r;
  logic [1:0]  level_r;
  logic [2:0]  mode_r;
  logic        song_load_r;
  logic        game_over_r;
  logic        won_r;
  logic [7:0]  final_hits_r;
  logic        counting_s;
  logic        beat_tick_s;
  logic        state_chg_s;

  // Two-flop synchronizers, a previous-value flop, and registered rising-edge pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sh_r <= 3'b000;
      sel_sh_r   <= 3'b000;
      start_p_r  <= 1'b0;
      sel_p_r    <= 1'b0;
    end else begin
      start_sh_r <= {start_sh_r[1:0], start_btn};
      sel_sh_r   <= {sel_sh_r[1:0], sel_btn};
      start_p_r  <= start_sh_r[1] & ~start_sh_r[2];
      sel_p_r    <= sel_sh_r[1] & ~sel_sh_r[2];
    end
  end

  assign counting_s  = (state_r == S_COUNTDOWN) || (state_r == S_PLAY);
  assign beat_tick_s = counting_s && (tick_cnt_r == (diff_r - 23'd1));
  assign state_chg_s = (next_state_s != state_r);

  // Next-state logic; the miss check in PLAY outranks the final beat
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_p_r) next_state_s = S_SELECT;
        else           next_state_s = state_r;
      end
      S_SELECT: begin
        if (start_p_r) next_state_s = S_COUNTDOWN;
        else           next_state_s = state_r;
      end
      S_COUNTDOWN: begin
        if (beat_tick_s && (beat_cnt_r == COUNT_LAST)) next_state_s = S_PLAY;
        else                                           next_state_s = state_r;
      end
      S_PLAY: begin
        if (num_misses >= MISS_LIMIT)                      next_state_s = S_LOSE;
        else if (beat_tick_s && (beat_cnt_r == SONG_LAST)) next_state_s = S_WIN;
        else                                               next_state_s = state_r;
      end
      S_WIN, S_LOSE: begin
        if (start_p_r) next_state_s = S_IDLE;
        else           next_state_s = state_r;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= next_state_s;
  end

  // Beat timebase; both counters restart on every phase change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_r <= 23'd0;
      beat_cnt_r <= 6'd0;
    end else if (state_chg_s || !counting_s) begin
      tick_cnt_r <= 23'd0;
      beat_cnt_r <= 6'd0;
    end else if (beat_tick_s) begin
      tick_cnt_r <= 23'd0;
      if (beat_cnt_r != 6'd63) beat_cnt_r <= beat_cnt_r + 6'd1;
    end else begin
      tick_cnt_r <= tick_cnt_r + 23'd1;
    end
  end

  // Difficulty: level moves only in SELECT (start wins a tie), diff trails it by one clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_r <= 2'd0;
      diff_r  <= DIFF_EASY;
    end else begin
      if ((state_r == S_SELECT) && sel_p_r && !start_p_r)
        level_r <= (level_r == 2'd2) ? 2'd0 : level_r + 2'd1;
      case (level_r)
        2'd0:    diff_r <= DIFF_EASY;
        2'd1:    diff_r <= DIFF_MED;
        2'd2:    diff_r <= DIFF_HARD;
        default: diff_r <= DIFF_EASY;
      endcase
    end
  end

  // Registered phase outputs, song ROM load strobe and final hit latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r       <= 3'd0;
      song_load_r  <= 1'b0;
      game_over_r  <= 1'b0;
      won_r        <= 1'b0;
      final_hits_r <= 8'd0;
    end else begin
      mode_r      <= next_state_s;
      song_load_r <= (state_r == S_SELECT) && start_p_r;
      game_over_r <= (next_state_s == S_WIN) || (next_state_s == S_LOSE);
      won_r       <= (next_state_s == S_WIN);
      if ((state_r == S_PLAY) && (next_state_s != S_PLAY)) final_hits_r <= num_hits;
    end
  end

  assign mode       = mode_r;
  assign diff       = diff_r;
  assign level      = level_r;
  assign song_load  = song_load_r;
  assign beat_cnt   = beat_cnt_r;
  assign game_over  = game_over_r;
  assign won        = won_r;
  assign final_hits = final_hits_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with shortened timebase (diff 4/3/2, 3+5 beats).
module tb_game_sequencer;

  logic        clk;
  logic        rst;
  logic        start_btn;
  logic        sel_btn;
  logic [7:0]  num_misses;
  logic [7:0]  num_hits;
  logic [2:0]  mode;
  logic [22:0] diff;
  logic [1:0]  level;
  logic        song_load;
  logic [5:0]  beat_cnt;
  logic        game_over;
  logic        won;
  logic [7:0]  final_hits;

  int checks = 0;
  int errors = 0;

  game_sequencer #(
    .DIFF_EASY(23'd4), .DIFF_MED(23'd3), .DIFF_HARD(23'd2),
    .COUNT_BEATS(3), .SONG_BEATS(5), .MISS_LIMIT(8'd10)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .sel_btn(sel_btn),
    .num_misses(num_misses), .num_hits(num_hits), .mode(mode), .diff(diff),
    .level(level), .song_load(song_load), .beat_cnt(beat_cnt),
    .game_over(game_over), .won(won), .final_hits(final_hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        sel;
    int          ncyc;
    logic [2:0]  mode;
    logic [1:0]  level;
    logic [22:0] diff;
    logic [5:0]  beat;
    logic        sl;
    logic        go;
    logic        won;
    logic [7:0]  fh;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [44:0] pk(input logic [2:0] m, input logic [1:0] l,
                                     input logic [22:0] d, input logic [5:0] b,
                                     input logic sl, input logic go, input logic w,
                                     input logic [7:0] fh);
    return {m, l, d, b, sl, go, w, fh};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [44:0] exp);
    logic [44:0] act;
    act = {mode, level, diff, beat_cnt, song_load, game_over, won, final_hits};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {mode,level,diff,beat,sl,go,won,fh}=%h expected %h",
               name, act, exp);
    end
  endtask

  task automatic press_start();
    start_btn = 1'b1; step(1); start_btn = 1'b0; step(3);
  endtask

  task automatic press_sel();
    sel_btn = 1'b1; step(1); sel_btn = 1'b0; step(3);
  endtask

  initial begin
    rst = 1'b1; start_btn = 1'b0; sel_btn = 1'b0; num_misses = 8'd0; num_hits = 8'd37;

    // start sel ncyc | mode level diff beat sl go won fh
    vecs[0]  = '{1'b0, 1'b0, 2,  3'd0, 2'd0, 23'd4, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 4,  3'd1, 2'd0, 23'd4, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 4,  3'd1, 2'd1, 23'd4, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 1,  3'd1, 2'd1, 23'd3, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 4,  3'd1, 2'd2, 23'd3, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 1'b0, 1,  3'd1, 2'd2, 23'd2, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 1'b1, 4,  3'd1, 2'd0, 23'd2, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 1'b0, 1,  3'd1, 2'd0, 23'd4, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{1'b1, 1'b0, 4,  3'd2, 2'd0, 23'd4, 6'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 1'b0, 1,  3'd2, 2'd0, 23'd4, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 1'b0, 10, 3'd2, 2'd0, 23'd4, 6'd2, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[11] = '{1'b0, 1'b0, 1,  3'd3, 2'd0, 23'd4, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[12] = '{1'b1, 1'b0, 19, 3'd3, 2'd0, 23'd4, 6'd4, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[13] = '{1'b0, 1'b0, 1,  3'd4, 2'd0, 23'd4, 6'd0, 1'b0, 1'b1, 1'b1, 8'd37};
    vecs[14] = '{1'b1, 1'b0, 4,  3'd0, 2'd0, 23'd4, 6'd0, 1'b0, 1'b0, 1'b0, 8'd37};
    vecs[15] = '{1'b0, 1'b0, 1,  3'd0, 2'd0, 23'd4, 6'd0, 1'b0, 1'b0, 1'b0, 8'd37};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Level wrap, win path and start-ignored-in-PLAY
    for (int i = 0; i < 16; i++) begin
      start_btn = vecs[i].start;
      sel_btn   = vecs[i].sel;
      step(vecs[i].ncyc);
      chk($sformatf("vec%0d", i), pk(vecs[i].mode, vecs[i].level, vecs[i].diff,
          vecs[i].beat, vecs[i].sl, vecs[i].go, vecs[i].won, vecs[i].fh));
    end

    // Early loss at beat 2 of PLAY
    num_hits = 8'd20; num_misses = 8'd9;
    press_start();
    press_start();
    step(12);
    chk("loss_play_entry", pk(3'd3, 2'd0, 23'd4, 6'd0, 1'b0, 1'b0, 1'b0, 8'd37));
    step(8);
    chk("loss_beat2", pk(3'd3, 2'd0, 23'd4, 6'd2, 1'b0, 1'b0, 1'b0, 8'd37));
    num_misses = 8'd10; num_hits = 8'd21;
    step(1);
    chk("loss_enter", pk(3'd5, 2'd0, 23'd4, 6'd0, 1'b0, 1'b1, 1'b0, 8'd21));
    num_misses = 8'd0;
    press_start();
    chk("loss_to_idle", pk(3'd0, 2'd0, 23'd4, 6'd0, 1'b0, 1'b0, 1'b0, 8'd21));

    // Loss beats win on the final beat tick
    press_start();
    press_start();
    step(12);
    step(19);
    chk("prio_last_beat", pk(3'd3, 2'd0, 23'd4, 6'd4, 1'b0, 1'b0, 1'b0, 8'd21));
    num_misses = 8'd10; num_hits = 8'd5;
    step(1);
    chk("prio_lose", pk(3'd5, 2'd0, 23'd4, 6'd0, 1'b0, 1'b1, 1'b0, 8'd5));
    num_misses = 8'd0;
    press_start();
    chk("prio_idle", pk(3'd0, 2'd0, 23'd4, 6'd0, 1'b0, 1'b0, 1'b0, 8'd5));

    // Simultaneous sel+start in SELECT at level 1
    press_start();
    press_sel();
    chk("sel_lvl1", pk(3'd1, 2'd1, 23'd4, 6'd0, 1'b0, 1'b0, 1'b0, 8'd5));
    step(1);
    chk("sel_diff3", pk(3'd1, 2'd1, 23'd3, 6'd0, 1'b0, 1'b0, 1'b0, 8'd5));
    start_btn = 1'b1; sel_btn = 1'b1;
    step(1);
    start_btn = 1'b0; sel_btn = 1'b0;
    step(3);
    chk("both_btn", pk(3'd2, 2'd1, 23'd3, 6'd0, 1'b1, 1'b0, 1'b0, 8'd5));
    step(9);
    chk("med_play", pk(3'd3, 2'd1, 23'd3, 6'd0, 1'b0, 1'b0, 1'b0, 8'd5));

    // Asynchronous reset mid-PLAY
    rst = 1'b1;
    #2;
    chk("reset_mid_play", pk(3'd0, 2'd0, 23'd4, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0));
    step(2);
    rst = 1'b0;
    step(1);

    // Held button gives one pulse only
    start_btn = 1'b1;
    step(100);
    chk("held_start", pk(3'd1, 2'd0, 23'd4, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0));
    start_btn = 1'b0;
    step(5);
    chk("held_release", pk(3'd1, 2'd0, 23'd4, 6'd0, 1'b0, 1'b0, 1'b0, 8'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level controller that sequences one round of the rhythm game around main_game.
- Selects difficulty (the 23-bit diff scroll limit) and steps through idle, select, countdown, play and result phases.
- Drives mode to main_game and watches the miss/hit counters to end the round early on too many misses.
- Counts song beats with its own timebase, matched to main_game's scroll rate, and pulses song_load so the song ROM presents notes1/notes2 before play.

Parameters:
- DIFF_EASY, 23'd6_000_000, diff for level 0
- DIFF_MED, 23'd4_000_000, diff for level 1
- DIFF_HARD, 23'd2_000_000, diff for level 2
- COUNT_BEATS, 3, countdown length in beats
- SONG_BEATS, 40, play length in beats (note columns incl. padding)
- MISS_LIMIT, 8'd10, misses at which the round is lost

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start_btn  in  1  raw start button (async)
- sel_btn  in  1  raw difficulty-select button (async)
- num_misses  in  8  from main_game
- num_hits  in  8  from main_game
- mode  out  3  phase code to main_game
- diff  out  23  scroll limit to main_game
- level  out  2  current difficulty 0..2
- song_load  out  1  1-cycle pulse: ROM latch notes1/notes2
- beat_cnt  out  6  beats elapsed in current phase
- game_over  out  1  high in WIN or LOSE
- won  out  1  high only in WIN
- final_hits  out  8  num_hits latched at play end

Behaviour:
- Inputs: each button is synchronized by 2 FFs, then rising-edge detected into a 1-cycle pulse (start_p, sel_p). Latency is 3 clk from the raw edge to the pulse.
- Timebase:
  - tick_cnt (23b) increments every clk while in COUNTDOWN or PLAY. It is cleared on every state change.
  - When tick_cnt == diff - 1, tick_cnt wraps to 0 and beat_tick pulses for 1 cycle.
  - beat_cnt increments on beat_tick and is cleared on every state change.
- States and mode codes: IDLE=0, SELECT=1, COUNTDOWN=2, PLAY=3, WIN=4, LOSE=5. Codes 6 and 7 are unused; either one returns the FSM to IDLE on the next clk.
- Transitions:
  - IDLE -> SELECT on start_p.
  - SELECT:
    - sel_p sets level = (level == 2) ? 0 : level + 1.
    - start_p moves to COUNTDOWN and asserts song_load in that same transition cycle.
    - If sel_p and start_p arrive in the same cycle, start wins and level is unchanged.
  - COUNTDOWN -> PLAY on the beat_tick that makes beat_cnt reach COUNT_BEATS.
  - PLAY:
    - Loss check: if num_misses >= MISS_LIMIT, go to LOSE. This check has priority.
    - Otherwise, the beat_tick that makes beat_cnt reach SONG_BEATS goes to WIN.
    - The loss check is evaluated every clk, not only on ticks.
  - Final hits: on the PLAY exit cycle, final_hits <= num_hits.
  - WIN/LOSE -> IDLE on start_p. sel_p is ignored in these states.
  - start_p during COUNTDOWN or PLAY is ignored. No pause.
- diff is registered from level: 0 -> DIFF_EASY, 1 -> DIFF_MED, 2 -> DIFF_HARD. It is 1 clk behind level.
- Level freeze: level changes only in SELECT, so diff is constant for the whole round.
- Outputs:
  - mode is a registered copy of the state.
  - game_over = (state == WIN || state == LOSE).
  - won = (state == WIN).
- Reset: async on rst high. Every output clears, tick_cnt, beat_cnt and the sync/edge FFs clear, and the FSM enters IDLE.
  - After reset, diff = DIFF_EASY.
  - Mid-round reset returns to IDLE with no song_load and no final_hits update.
- Width rules:
  - beat_cnt saturates at 63 and must not wrap.
  - tick_cnt compare is full 23-bit; diff values 0 and 1 are not supported.

Test Plan:
- Reset defaults: rst pulse mid-PLAY -> mode=0, level=0, diff=DIFF_EASY, beat_cnt=0, game_over=0, final_hits=0, song_load=0.
- Level wrap: override DIFF_* = 4/3/2. In SELECT, 3 sel presses -> level 1, 2, 0 and diff 3, 2, 4, each 1 clk after the level change.
- Win path: DIFF_EASY=4, COUNT_BEATS=3, SONG_BEATS=5, level 0, start -> song_load 1 cycle on SELECT->COUNTDOWN.
  - PLAY is entered 12 clk later.
  - WIN is entered 20 clk after that.
  - With num_hits=37 held, final_hits=37, won=1, mode=4.
- Early loss: in PLAY, drive num_misses 9 -> 10 at beat 2 -> LOSE next clk, mode=5, won=0, final_hits = num_hits sampled that cycle.
- Priority: num_misses=10 on the same cycle as the final beat_tick -> LOSE, not WIN.
- Ignored inputs:
  - start during PLAY -> no state change.
  - Simultaneous sel+start in SELECT -> COUNTDOWN, level unchanged.
  - Button held high 100 clk -> exactly one pulse.
